// File: rtl/dispatch_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_pkg
// Shared constants and types for the clause dispatch controller.
//   NUM_ENGINE : number of BCP engines / grant lines
//   CRED_MAX   : per-engine input queue depth (credits after reset)
//   CNT_W      : width of the load / dispatch clause counters
// -----------------------------------------------------------------------------
package dispatch_pkg;

    localparam int NUM_ENGINE = 4;
    localparam int CRED_MAX   = 4;
    localparam int CNT_W      = 10;
    localparam int CRED_W     = $clog2(CRED_MAX + 1);
    localparam int IDX_W      = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

    typedef logic [CRED_W-1:0] cred_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [IDX_W-1:0]  idx_t;

    localparam cred_t CRED_FULL = cred_t'(CRED_MAX);
    localparam cnt_t  CNT_FULL  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DONE     = 2'd2
    } state_t;

    // Round-robin pointer advance: the engine after the winner, wrapping.
    function automatic idx_t next_ptr(input idx_t idx);
        return (int'(idx) == NUM_ENGINE - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Scans requesters starting at i_ptr and
// wrapping; the first active request wins.
//   i_req   : request vector (one bit per requester)
//   i_ptr   : index where the scan starts
//   o_grant : one-hot winner (all zero when nothing requests)
//   o_idx   : index of the winner (zero when nothing requests)
//   o_any   : at least one request is active
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        logic [IDX_W-1:0] w_cand;
        w_cand  = '0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/clause_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// clause_dispatch_ctrl
// Sequences the clause distribution datapath: counts clauses loaded into the
// clause buffer, then after start pops one clause per cycle and hands it to a
// BCP engine chosen round-robin among engines that still hold credits.
//   clock, reset   : clock / asynchronous active-low reset
//   load_sig_in    : one clause written into the buffer this cycle
//   start_in       : begin dispatch (honoured in IDLE only)
//   clear_in       : synchronous return to IDLE, counters and err cleared
//   src_empty_in   : clause buffer empty
//   eng_pop_in     : engine i consumed a clause, returning one credit
//   pop_out        : pop the clause buffer this cycle
//   grant_out      : one-hot destination engine of the popped clause
//   busy_out       : dispatching
//   done_out       : every loaded clause has been dispatched
//   load_cnt_out   : clauses loaded
//   disp_cnt_out   : clauses dispatched
//   err_out        : sticky error (load counter overflow or credit overflow)
// -----------------------------------------------------------------------------
module clause_dispatch_ctrl
    import dispatch_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_sig_in,
    input  logic                  start_in,
    input  logic                  clear_in,
    input  logic                  src_empty_in,
    input  logic [NUM_ENGINE-1:0] eng_pop_in,
    output logic                  pop_out,
    output logic [NUM_ENGINE-1:0] grant_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [CNT_W-1:0]      load_cnt_out,
    output logic [CNT_W-1:0]      disp_cnt_out,
    output logic                  err_out
);

    state_t r_state;
    logic   r_busy;
    logic   r_done;
    cnt_t   r_load_cnt;
    cnt_t   r_disp_cnt;
    logic   r_err;
    idx_t   r_rr_ptr;
    cred_t  r_credit [NUM_ENGINE];

    cnt_t                  w_pending;
    logic [NUM_ENGINE-1:0] w_req;
    logic [NUM_ENGINE-1:0] w_arb_grant;
    idx_t                  w_arb_idx;
    logic                  w_arb_any;
    logic                  w_can_grant;
    logic [NUM_ENGINE-1:0] w_grant;
    logic                  w_load_ovf;
    logic                  w_pop_ovf;

    // The dispatcher never grants beyond what was loaded, so the difference
    // cannot wrap.
    assign w_pending = r_load_cnt - r_disp_cnt;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            w_req[i] = (r_credit[i] != '0);
        end
    end

    rr_arbiter #(
        .N     (NUM_ENGINE),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    assign w_can_grant = (r_state == DISPATCH) && (w_pending != '0) &&
                         !src_empty_in && w_arb_any;
    assign w_grant     = w_can_grant ? w_arb_grant : '0;

    // A credit return to an engine that is already full, with no grant to
    // offset it, means the engine popped more than it was sent.
    always_comb begin
        w_pop_ovf = 1'b0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            if (eng_pop_in[i] && !w_grant[i] && (r_credit[i] == CRED_FULL)) begin
                w_pop_ovf = 1'b1;
            end
        end
    end

    assign w_load_ovf = load_sig_in && (r_load_cnt == CNT_FULL);

    // NOTE: all state here is sequential and uses non-blocking assignments so
    // every register samples the pre-edge values of its peers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_load_cnt <= '0;
            r_disp_cnt <= '0;
            r_err      <= 1'b0;
            r_rr_ptr   <= '0;
            // NOTE: the credit array is a handful of flops that must start
            // full, so it is reset explicitly; a RAM-backed array would not be.
            for (int i = 0; i < NUM_ENGINE; i++) begin
                r_credit[i] <= CRED_FULL;
            end
        end else begin
            // Credits and the pointer track what actually moved on the wires,
            // so clear_in does not touch them.
            if (w_can_grant) begin
                r_rr_ptr <= next_ptr(w_arb_idx);
            end
            for (int i = 0; i < NUM_ENGINE; i++) begin
                if (w_grant[i] && !eng_pop_in[i]) begin
                    r_credit[i] <= r_credit[i] - 1'b1;
                end else if (!w_grant[i] && eng_pop_in[i] && (r_credit[i] != CRED_FULL)) begin
                    r_credit[i] <= r_credit[i] + 1'b1;
                end
            end

            if (clear_in) begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_load_cnt <= '0;
                r_disp_cnt <= '0;
                r_err      <= 1'b0;
            end else begin
                if (load_sig_in && !w_load_ovf) begin
                    r_load_cnt <= r_load_cnt + 1'b1;
                end
                if (w_can_grant) begin
                    r_disp_cnt <= r_disp_cnt + 1'b1;
                end
                if (w_load_ovf || w_pop_ovf) begin
                    r_err <= 1'b1;
                end

                case (r_state)
                    IDLE: begin
                        if (start_in) begin
                            r_state <= DISPATCH;
                            r_busy  <= 1'b1;
                        end
                    end
                    DISPATCH: begin
                        // A load in the cycle pending drains keeps us here.
                        if ((w_pending == '0) && !load_sig_in) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (load_sig_in) begin
                            r_state <= DISPATCH;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pop_out      = w_can_grant;
    assign grant_out    = w_grant;
    assign busy_out     = r_busy;
    assign done_out     = r_done;
    assign load_cnt_out = r_load_cnt;
    assign disp_cnt_out = r_disp_cnt;
    assign err_out      = r_err;

endmodule
